// File: rtl/wb_pkg.sv
// Shared Wishbone responder types: response-pipe entry and latency bounds.
package wb_pkg;

  typedef struct packed {
    logic valid;
    logic err;
  } resp_entry_t;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_OUTSTANDING_LIMIT = 8;

  localparam resp_entry_t RESP_IDLE = '{valid: 1'b0, err: 1'b0};

  // Byte-lane bits below the memory word index.
  function automatic int word_lsb(input int select_width);
    return $clog2(select_width);
  endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Depth-N shift register of response entries with a synchronous flush.
// Exposes the last two stages: the one feeding the ack register and the retiring one.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  resp_entry_t in_entry,
  output resp_entry_t tap_prev,
  output resp_entry_t tap_last
);

  resp_entry_t stage_q [DEPTH];
  resp_entry_t stage_d [DEPTH];

  // Next-state of every stage: shift by one, or clear everything on flush.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = RESP_IDLE;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = RESP_IDLE;
      end
    end else begin
      stage_d[0] = in_entry;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESP_IDLE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tap_prev = stage_q[DEPTH-2];
  assign tap_last = stage_q[DEPTH-1];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined responder in front of a fixed-latency single-port memory.
// Optional WB_MEM_RESPONDER_ADDR_CHECK_EN: out-of-range words terminate with wb_err.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH  = 14,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     wb_adr,
  input  logic [DATA_WIDTH-1:0]     wb_dat_w,
  input  logic [SELECT_WIDTH-1:0]   wb_sel,
  input  logic                      wb_we,
  input  logic                      wb_cyc,
  input  logic                      wb_stb,
  output logic                      wb_stall,
  output logic                      wb_ack,
  output logic                      wb_err,
  output logic [DATA_WIDTH-1:0]     wb_dat_r,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [SELECT_WIDTH-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int SEL_LSB   = word_lsb(SELECT_WIDTH);
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int PIPE_DEPTH = READ_LATENCY + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wb_ack_q, wb_ack_d;
  logic                  wb_err_q, wb_err_d;
  logic [DATA_WIDTH-1:0] wb_dat_r_q, wb_dat_r_d;

  logic        accept;
  logic        retire;
  logic        flush;
  logic        addr_oor;
  resp_entry_t pipe_in;
  resp_entry_t tap_prev;
  resp_entry_t tap_last;

  // Stall looks only at the registered count, so a same-cycle ack cannot unstall.
  assign wb_stall = (count_q == CNT_MAX);
  assign accept   = wb_cyc & wb_stb & ~wb_stall;
  assign flush    = ~wb_cyc;
  assign retire   = tap_last.valid;

`ifdef WB_MEM_RESPONDER_ADDR_CHECK_EN
  assign addr_oor = |wb_adr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+SEL_LSB];
`else
  assign addr_oor = 1'b0;
`endif

  assign mem_req   = accept & ~addr_oor;
  assign mem_we    = wb_we;
  assign mem_addr  = wb_adr[MEM_ADDR_WIDTH+SEL_LSB-1:SEL_LSB];
  assign mem_be    = wb_sel;
  assign mem_wdata = wb_dat_w;

  assign pipe_in = '{valid: accept, err: accept & addr_oor};

  wb_resp_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_entry (pipe_in),
    .tap_prev (tap_prev),
    .tap_last (tap_last)
  );

  // Outstanding count: +1 per accept, -1 per retire, cleared on abort.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({accept, retire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Next termination: the entry whose memory data is on mem_rdata this cycle.
  always_comb begin
    wb_ack_d   = 1'b0;
    wb_err_d   = 1'b0;
    wb_dat_r_d = wb_dat_r_q;
    if (!flush && tap_prev.valid) begin
      if (tap_prev.err) begin
        wb_err_d = 1'b1;
      end else begin
        wb_ack_d   = 1'b1;
        wb_dat_r_d = mem_rdata;
      end
    end else begin
      wb_ack_d = 1'b0;
      wb_err_d = 1'b0;
    end
  end

  // Count and termination registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wb_ack_q   <= 1'b0;
      wb_err_q   <= 1'b0;
      wb_dat_r_q <= '0;
    end else begin
      count_q    <= count_d;
      wb_ack_q   <= wb_ack_d;
      wb_err_q   <= wb_err_d;
      wb_dat_r_q <= wb_dat_r_d;
    end
  end

  assign wb_ack   = wb_ack_q;
  assign wb_err   = wb_err_q;
  assign wb_dat_r = wb_dat_r_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: transaction-level model plus directed literals,
// followed by randomized traffic with aborts and resets.
module tb_wb_mem_responder;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int MAW = 14;
  localparam int RL  = 3;
  localparam int MO  = 4;
  localparam int WORDS = 1 << MAW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_w;
  logic [SW-1:0] wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic          wb_stall, wb_ack, wb_err;
  logic [DW-1:0] wb_dat_r;
  logic          mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  wb_mem_responder #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .SELECT_WIDTH    (SW),
    .MEM_ADDR_WIDTH  (MAW),
    .READ_LATENCY    (RL),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_adr    (wb_adr),
    .wb_dat_w  (wb_dat_w),
    .wb_sel    (wb_sel),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_stall  (wb_stall),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_dat_r  (wb_dat_r),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    case (i)
      0:       return 32'h0BAD_F00D;
      4:       return 32'hDEAD_BEEF;
      8:       return 32'h0000_0000;
      default: return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory environment: fixed read latency RL, byte-enabled writes, junk when idle.
  logic [DW-1:0] env_mem [WORDS];
  logic [DW-1:0] rd_pipe [RL];
  bit            env_init_done = 1'b0;
  logic [DW-1:0] env_w;

  always @(posedge clk) begin
    if (!env_init_done) begin
      for (int i = 0; i < WORDS; i++) env_mem[i] <= init_word(i);
      env_init_done <= 1'b1;
    end else if (mem_req && mem_we) begin
      env_w = env_mem[mem_addr];
      for (int b = 0; b < SW; b++) if (mem_be[b]) env_w[8*b +: 8] = mem_wdata[8*b +: 8];
      env_mem[mem_addr] <= env_w;
    end
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_req && !mem_we) rd_pipe[0] <= env_mem[mem_addr];
    else rd_pipe[0] <= $urandom;
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Reference model: queue of accepted transactions, each due RL+1 cycles later.
  typedef struct {
    int            ack_cyc;
    bit            err;
    bit            is_wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          pend[$];
  logic [DW-1:0] shadow [WORDS];
  logic [DW-1:0] exp_dat;
  bit            dat_known;
  bit            model_on = 1'b0;
  int            tcyc = 0;
  int            tests = 0;
  int            fails = 0;

  logic          obs_stall, obs_ack, obs_err, obs_req;
  logic [MAW-1:0] obs_addr;
  logic [DW-1:0] obs_dat;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, tcyc, got, exp);
    end
  endtask

  function automatic bit addr_out_of_range(input logic [AW-1:0] a);
`ifdef WB_MEM_RESPONDER_ADDR_CHECK_EN
    return (a >> (MAW + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle comparison of every meaningful output against the model, then model advance.
  task automatic check_model();
    bit            e_stall, e_acc, e_req, oor, due;
    int            word;
    exp_t          e;
    tcyc++;
    obs_stall = wb_stall; obs_ack = wb_ack; obs_err = wb_err;
    obs_req = mem_req; obs_addr = mem_addr; obs_dat = wb_dat_r;
    if (model_on) begin
      e_stall = (pend.size() == MO);
      e_acc   = wb_cyc && wb_stb && !e_stall;
      oor     = addr_out_of_range(wb_adr);
      word    = int'((wb_adr >> 2) & 32'(WORDS - 1));
      e_req   = e_acc && !oor;
      chk("stall", 64'(wb_stall), 64'(e_stall));
      chk("mem_req", 64'(mem_req), 64'(e_req));
      if (e_req) begin
        chk("mem_addr", 64'(mem_addr), 64'(word));
        chk("mem_we", 64'(mem_we), 64'(wb_we));
        chk("mem_be", 64'(mem_be), 64'(wb_sel));
        chk("mem_wdata", 64'(mem_wdata), 64'(wb_dat_w));
      end
      due = (pend.size() > 0) && (pend[0].ack_cyc == tcyc);
      chk("ack", 64'(wb_ack), 64'(due && !pend[0].err));
      chk("err", 64'(wb_err), 64'(due && pend[0].err));
      if (due && !pend[0].err) begin
        if (pend[0].is_wr) dat_known = 1'b0;
        else begin dat_known = 1'b1; exp_dat = pend[0].data; end
      end
      if (dat_known) chk("dat_r", 64'(wb_dat_r), 64'(exp_dat));
      if (!rst) begin
        if (!wb_cyc) pend.delete();
        else begin
          if (due) void'(pend.pop_front());
          if (e_acc) begin
            e.ack_cyc = tcyc + RL + 1;
            e.err     = oor;
            e.is_wr   = wb_we;
            e.data    = shadow[word];
            pend.push_back(e);
            if (wb_we && !oor)
              for (int b = 0; b < SW; b++)
                if (wb_sel[b]) shadow[word][8*b +: 8] = wb_dat_w[8*b +: 8];
          end
        end
      end
    end
    if (rst) begin
      if (!model_on) for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
      model_on  = 1'b1;
      pend.delete();
      exp_dat   = '0;
      dat_known = 1'b1;
    end
  endtask

  task automatic step(input bit c, input bit s, input bit w, input logic [AW-1:0] a,
                      input logic [SW-1:0] sel, input logic [DW-1:0] d);
    wb_cyc = c; wb_stb = s; wb_we = w; wb_adr = a; wb_sel = sel; wb_dat_w = d;
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  int hits;

  initial begin
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("reset_ack", 64'(obs_ack), 64'd0);
    chk("reset_stall", 64'(obs_stall), 64'd0);
    chk("reset_dat", 64'(obs_dat), 64'd0);

    // Single read of word 4: ack exactly RL+1 cycles later.
    step(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    chk("rd_req", 64'(obs_req), 64'd1);
    chk("rd_addr", 64'(obs_addr), 64'd4);
    idle(3);
    chk("rd_ack_early", 64'(obs_ack), 64'd0);
    idle(1);
    chk("rd_ack", 64'(obs_ack), 64'd1);
    chk("rd_dat", 64'(obs_dat), 64'hDEAD_BEEF);
    idle(1);
    chk("rd_ack_single", 64'(obs_ack), 64'd0);

    // Partial write to word 8 followed by a read of the same word.
    step(1'b1, 1'b1, 1'b1, 32'h20, 4'b0011, 32'hA5A5_A5A5);
    step(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
    idle(3);
    chk("wr_ack", 64'(obs_ack), 64'd1);
    idle(1);
    chk("wr_rd_ack", 64'(obs_ack), 64'd1);
    chk("wr_rd_dat", 64'(obs_dat), 64'h0000_A5A5);
    idle(2);

    // Backpressure: MO accepts fill the count; the next cycle stalls.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, '0);
      if (i == 3) chk("no_stall_yet", 64'(obs_stall), 64'd0);
      if (i == 4) chk("stall_full", 64'(obs_stall), 64'd1);
    end
    idle(8);

    // Abort with three reads pending: no terminations afterwards.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'(i * 4), 4'hF, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (obs_ack || obs_err) hits++;
    end
    chk("abort_no_ack", 64'(hits), 64'd0);
    chk("abort_unstalled", 64'(obs_stall), 64'd0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    idle(4);
    chk("post_abort_ack", 64'(obs_ack), 64'd1);
    chk("post_abort_dat", 64'(obs_dat), 64'hDEAD_BEEF);
    idle(1);

    // Reset with two reads pending.
    step(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, '0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (obs_ack || obs_err) hits++;
      if (i == 0) chk("rst_dat_clear", 64'(obs_dat), 64'd0);
    end
    chk("rst_no_ack", 64'(hits), 64'd0);

    // Address above the memory range.
    step(1'b1, 1'b1, 1'b0, 32'h0001_0000, 4'hF, '0);
`ifdef WB_MEM_RESPONDER_ADDR_CHECK_EN
    chk("oor_no_req", 64'(obs_req), 64'd0);
    idle(4);
    chk("oor_err", 64'(obs_err), 64'd1);
    chk("oor_no_ack", 64'(obs_ack), 64'd0);
`else
    chk("alias_req", 64'(obs_req), 64'd1);
    chk("alias_addr", 64'(obs_addr), 64'd0);
    idle(4);
    chk("alias_ack", 64'(obs_ack), 64'd1);
    chk("alias_dat", 64'(obs_dat), 64'h0BAD_F00D);
`endif
    idle(2);

    // Randomized traffic with occasional aborts, resets and out-of-range addresses.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a;
      bit c, s;
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(16, 31));
      c = ($urandom_range(0, 99) >= 4);
      s = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 199) == 0);
      if (rst) s = 1'b0;
      step(c, s, 1'($urandom_range(0, 9) < 4), a, 4'($urandom), 32'($urandom));
    end
    rst = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
